// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the 16-bit 5-stage pipeline:
// operand-mux select codes and forwarding/hazard FSM states.
package cpu_ctrl_pkg;

    localparam int REG_AW_DEF = 4;

    localparam logic [1:0] SEL_RF    = 2'd0;
    localparam logic [1:0] SEL_EXMEM = 2'd1;
    localparam logic [1:0] SEL_MEMWB = 2'd2;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_MULDIV = 1'b1
    } state_t;

endpackage

// File: rtl/fwd_sel.sv
// Priority comparator for one ALU operand: EX/MEM beats MEM/WB,
// which beats the register file.
module fwd_sel
    import cpu_ctrl_pkg::*;
#(
    parameter int REG_AW   = REG_AW_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic              ex_valid,
    input  logic [REG_AW-1:0] rs,
    input  logic              mem_valid,
    input  logic              mem_wr,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              wb_valid,
    input  logic              wb_wr,
    input  logic [REG_AW-1:0] wb_rd,
    output logic [1:0]        sel
);

    logic is_zero;
    logic mem_hit;
    logic wb_hit;

    always_comb begin
        is_zero = (ZERO_REG != 0) && (rs == '0);
        mem_hit = mem_valid && mem_wr && (mem_rd == rs);
        wb_hit  = wb_valid && wb_wr && (wb_rd == rs);
        sel     = SEL_RF;
        if (!ex_valid || is_zero) begin
            sel = SEL_RF;
        end else if (mem_hit) begin
            sel = SEL_EXMEM;
        end else if (wb_hit) begin
            sel = SEL_MEMWB;
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding, load-use stall and MUL/DIV sequencing control.
// Tracks EX/MEM/WB destination records; owns no datapath.
module fwd_hazard_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int REG_AW     = REG_AW_DEF,
    parameter int MULDIV_LAT = 4,
    parameter int ZERO_REG   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wr,
    input  logic              id_load,
    input  logic              id_muldiv,
    input  logic              flush,
    output logic [1:0]        selA,
    output logic [1:0]        selB,
    output logic              stall_if,
    output logic              bubble_ex,
    output logic              ex_first,
    output logic              busy
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic              wr;
        logic              load;
        logic              muldiv;
        logic              first;
    } ex_rec_t;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              wr;
    } wr_rec_t;

    localparam int CW = 5;
    localparam logic [CW-1:0] CNT_INIT =
        (MULDIV_LAT > 1) ? CW'(MULDIV_LAT - 2) : '0;
    localparam bit HAS_MD = (MULDIV_LAT > 1);

    ex_rec_t ex_q;
    wr_rec_t mem_q;
    wr_rec_t wb_q;
    state_t  st_q;
    logic [CW-1:0] cnt_q;

    ex_rec_t id_rec;
    wr_rec_t ex_wr;
    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic lu_haz;
    logic md_enter;
    logic md_hold;
    logic rs1_hit;
    logic rs2_hit;
    logic rd_zero;

    always_comb begin
        id_rec        = '0;
        id_rec.valid  = id_valid;
        id_rec.rs1    = id_rs1;
        id_rec.rs2    = id_rs2;
        id_rec.rd     = id_rd;
        id_rec.wr     = id_wr;
        id_rec.load   = id_load;
        id_rec.muldiv = id_muldiv;
        id_rec.first  = 1'b1;
    end

    always_comb begin
        ex_wr       = '0;
        ex_wr.valid = ex_q.valid;
        ex_wr.rd    = ex_q.rd;
        ex_wr.wr    = ex_q.wr;
    end

    fwd_sel #(
        .REG_AW   (REG_AW),
        .ZERO_REG (ZERO_REG)
    ) u_sel_a (
        .ex_valid  (ex_q.valid),
        .rs        (ex_q.rs1),
        .mem_valid (mem_q.valid),
        .mem_wr    (mem_q.wr),
        .mem_rd    (mem_q.rd),
        .wb_valid  (wb_q.valid),
        .wb_wr     (wb_q.wr),
        .wb_rd     (wb_q.rd),
        .sel       (sel_a)
    );

    fwd_sel #(
        .REG_AW   (REG_AW),
        .ZERO_REG (ZERO_REG)
    ) u_sel_b (
        .ex_valid  (ex_q.valid),
        .rs        (ex_q.rs2),
        .mem_valid (mem_q.valid),
        .mem_wr    (mem_q.wr),
        .mem_rd    (mem_q.rd),
        .wb_valid  (wb_q.valid),
        .wb_wr     (wb_q.wr),
        .wb_rd     (wb_q.rd),
        .sel       (sel_b)
    );

    // A load writing r0 never creates a dependency when r0 is hardwired.
    always_comb begin
        rd_zero  = (ZERO_REG != 0) && (ex_q.rd == '0);
        rs1_hit  = (ex_q.rd == id_rs1);
        rs2_hit  = (ex_q.rd == id_rs2);
        lu_haz   = (st_q == ST_RUN) && ex_q.valid && ex_q.load
                && ex_q.wr && id_valid && !rd_zero
                && (rs1_hit || rs2_hit);
        md_enter = HAS_MD && (st_q == ST_RUN) && ex_q.valid
                && ex_q.muldiv && ex_q.first;
        md_hold  = md_enter || ((st_q == ST_MULDIV) && (cnt_q != '0));
    end

    always_comb begin
        selA      = SEL_RF;
        selB      = SEL_RF;
        stall_if  = 1'b0;
        bubble_ex = 1'b0;
        ex_first  = 1'b0;
        busy      = 1'b0;
        if (rst_n) begin
            selA      = sel_a;
            selB      = sel_b;
            stall_if  = !flush && (lu_haz || md_hold);
            bubble_ex = flush || lu_haz;
            ex_first  = ex_q.valid && ex_q.first;
            busy      = (st_q == ST_MULDIV);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            st_q  <= ST_RUN;
            cnt_q <= '0;
        end else if (flush) begin
            ex_q  <= '0;
            mem_q <= ex_wr;
            wb_q  <= mem_q;
            st_q  <= ST_RUN;
            cnt_q <= '0;
        end else if (lu_haz) begin
            ex_q  <= '0;
            mem_q <= ex_wr;
            wb_q  <= mem_q;
        end else if (md_enter) begin
            ex_q.first <= 1'b0;
            mem_q      <= '0;
            wb_q       <= mem_q;
            cnt_q      <= CNT_INIT;
            st_q       <= ST_MULDIV;
        end else if (md_hold) begin
            mem_q <= '0;
            wb_q  <= mem_q;
            cnt_q <= cnt_q - 1'b1;
        end else begin
            ex_q  <= id_rec;
            mem_q <= ex_wr;
            wb_q  <= mem_q;
            st_q  <= ST_RUN;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl with MULDIV_LAT=4 and 1.
// Per-cycle vector table, expected outputs via a scoreboard queue.
module tb_fwd_hazard_ctrl;

    typedef struct {
        int         w;
        logic       r;
        logic       iv;
        logic [3:0] s1;
        logic [3:0] s2;
        logic [3:0] rd;
        logic       wr;
        logic       ld;
        logic       md;
        logic       fl;
        logic [1:0] a;
        logic [1:0] b;
        logic       st;
        logic       bu;
        logic       fi;
        logic       by;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [3:0] id_rs1;
    logic [3:0] id_rs2;
    logic [3:0] id_rd;
    logic       id_wr;
    logic       id_load;
    logic       id_muldiv;
    logic       flush;

    logic [1:0] a4, b4, a1, b1;
    logic       st4, bu4, fi4, by4;
    logic       st1, bu1, fi1, by1;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    fwd_hazard_ctrl #(.REG_AW(4), .MULDIV_LAT(4), .ZERO_REG(1)) u4 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_wr(id_wr), .id_load(id_load), .id_muldiv(id_muldiv),
        .flush(flush), .selA(a4), .selB(b4), .stall_if(st4),
        .bubble_ex(bu4), .ex_first(fi4), .busy(by4)
    );

    fwd_hazard_ctrl #(.REG_AW(4), .MULDIV_LAT(1), .ZERO_REG(1)) u1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_wr(id_wr), .id_load(id_load), .id_muldiv(id_muldiv),
        .flush(flush), .selA(a1), .selB(b1), .stall_if(st1),
        .bubble_ex(bu1), .ex_first(fi1), .busy(by1)
    );

    function automatic vec_t mk(
        int w, int r, int iv, int s1, int s2, int rd,
        int wr, int ld, int md, int fl,
        int a, int b, int st, int bu, int fi, int by
    );
        vec_t t;
        t.w  = w;
        t.r  = r[0];
        t.iv = iv[0];
        t.s1 = s1[3:0];
        t.s2 = s2[3:0];
        t.rd = rd[3:0];
        t.wr = wr[0];
        t.ld = ld[0];
        t.md = md[0];
        t.fl = fl[0];
        t.a  = a[1:0];
        t.b  = b[1:0];
        t.st = st[0];
        t.bu = bu[0];
        t.fi = fi[0];
        t.by = by[0];
        return t;
    endfunction

    task automatic chk(input string nm, input int row,
                       input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL row %0d %s: got %0d, expected %0d",
                     row, nm, got, want);
        end
    endtask

    task automatic drive(input vec_t v);
        rst_n     = v.r;
        id_valid  = v.iv;
        id_rs1    = v.s1;
        id_rs2    = v.s2;
        id_rd     = v.rd;
        id_wr     = v.wr;
        id_load   = v.ld;
        id_muldiv = v.md;
        flush     = v.fl;
        sb.push_back(v);
    endtask

    task automatic check_out(input int row);
        vec_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", row, 0, 1);
            return;
        end
        e = sb.pop_front();
        if (e.w == 1) begin
            chk("selA", row, a1, e.a);
            chk("selB", row, b1, e.b);
            chk("stall_if", row, st1, e.st);
            chk("bubble_ex", row, bu1, e.bu);
            chk("ex_first", row, fi1, e.fi);
            chk("busy", row, by1, e.by);
        end else begin
            chk("selA", row, a4, e.a);
            chk("selB", row, b4, e.b);
            chk("stall_if", row, st4, e.st);
            chk("bubble_ex", row, bu4, e.bu);
            chk("ex_first", row, fi4, e.fi);
            chk("busy", row, by4, e.by);
        end
    endtask

    task automatic step(input vec_t v, input int row);
        drive(v);
        @(negedge clk);
        check_out(row);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t nop4;
        nop4 = mk(0,1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0);
        rst_n = 1'b0;
        id_valid = 1'b1;
        id_rs1 = '0;
        id_rs2 = '0;
        id_rd = '0;
        id_wr = 1'b0;
        id_load = 1'b0;
        id_muldiv = 1'b0;
        flush = 1'b0;

        // reset held 2 cycles with a live ID instruction
        tbl.push_back(mk(0,0,1,1,2,3,1,0,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,0,1,1,2,3,1,0,0,0, 0,0,0,0,0,0));
        // ADD r3 ; SUB r4,r3,r3 ; NOP ; OR r5,r4,r1
        tbl.push_back(mk(0,1,1,1,2,3,1,0,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,1,1,3,3,4,1,0,0,0, 0,0,0,0,1,0));
        tbl.push_back(mk(0,1,0,0,0,0,0,0,0,0, 1,1,0,0,1,0));
        tbl.push_back(mk(0,1,1,4,1,5,1,0,0,0, 0,0,0,0,0,0));
        // ADD r3 ; NOP ; OR r5,r3,r1
        tbl.push_back(mk(0,1,1,1,2,3,1,0,0,0, 2,0,0,0,1,0));
        tbl.push_back(mk(0,1,0,0,0,0,0,0,0,0, 0,0,0,0,1,0));
        tbl.push_back(mk(0,1,1,3,1,5,1,0,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0,0,0,0,0,0, 2,0,0,0,1,0));
        // LW r2 ; ADD r6,r2,r7 (1-cycle load-use stall)
        tbl.push_back(mk(0,1,1,1,0,2,1,1,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,1,1,2,7,6,1,0,0,0, 0,0,1,1,1,0));
        tbl.push_back(mk(0,1,1,2,7,6,1,0,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0,0,0,0,0,0, 2,0,0,0,1,0));
        // r5 in MEM and WB, EX reads r5 and r0
        tbl.push_back(mk(0,1,1,1,1,5,1,0,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,1,1,1,1,5,1,0,0,0, 0,0,0,0,1,0));
        tbl.push_back(mk(0,1,1,5,0,7,1,0,0,0, 0,0,0,0,1,0));
        tbl.push_back(mk(0,1,1,1,1,0,1,0,0,0, 1,0,0,0,1,0));
        // r0 written by MEM and WB, EX reads r0,r0
        tbl.push_back(mk(0,1,1,1,1,0,1,0,0,0, 0,0,0,0,1,0));
        tbl.push_back(mk(0,1,1,1,1,0,1,0,0,0, 0,0,0,0,1,0));
        tbl.push_back(mk(0,1,1,0,0,8,1,0,0,0, 0,0,0,0,1,0));
        tbl.push_back(mk(0,1,0,0,0,0,0,0,0,0, 0,0,0,0,1,0));
        // LW r0 followed by a reader of r0: no stall
        tbl.push_back(mk(0,1,1,1,1,0,1,1,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,1,1,0,0,9,1,0,0,0, 0,0,0,0,1,0));
        tbl.push_back(mk(0,1,0,0,0,0,0,0,0,0, 0,0,0,0,1,0));

        foreach (tbl[i]) step(tbl[i], i);

        // MUL r10,r9,r1 held 4 cycles, ADD r11,r10,r2 waits in ID
        step(mk(0,1,1,9,1,10,1,0,1,0, 0,0,0,0,0,0), 100);
        step(mk(0,1,1,10,2,11,1,0,0,0, 2,0,1,0,1,0), 101);
        step(mk(0,1,1,10,2,11,1,0,0,0, 0,0,1,0,0,1), 102);
        step(mk(0,1,1,10,2,11,1,0,0,0, 0,0,1,0,0,1), 103);
        step(mk(0,1,1,10,2,11,1,0,0,0, 0,0,0,0,0,1), 104);
        step(mk(0,1,0,0,0,0,0,0,0,0, 1,0,0,0,1,0), 105);

        // flush while MULDIV counter is 1
        step(mk(0,1,1,1,2,12,1,0,1,0, 0,0,0,0,0,0), 200);
        step(mk(0,1,1,12,12,13,1,0,0,0, 0,0,1,0,1,0), 201);
        step(mk(0,1,1,12,12,13,1,0,0,0, 0,0,1,0,0,1), 202);
        step(mk(0,1,1,12,12,13,1,0,0,1, 0,0,0,1,0,1), 203);
        step(nop4, 204);

        // reset in the middle of MULDIV
        step(mk(0,1,1,1,2,12,1,0,1,0, 0,0,0,0,0,0), 300);
        step(mk(0,1,0,0,0,0,0,0,0,0, 0,0,1,0,1,0), 301);
        step(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0), 302);
        step(nop4, 303);

        // MULDIV_LAT=1 instance: MUL passes straight through
        step(mk(1,1,1,1,2,10,1,0,1,0, 0,0,0,0,0,0), 400);
        step(mk(1,1,1,10,3,11,1,0,0,0, 0,0,0,0,1,0), 401);
        step(mk(1,1,0,0,0,0,0,0,0,0, 1,0,0,0,1,0), 402);

        chk("scoreboard_drained", 999, sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
Forwarding and hazard controller for the 16-bit 5-stage pipeline.
- Tracks the destination registers of the instructions in EX, MEM and WB.
- Drives the two 2-bit operand-mux selects that feed the ALU.
- Detects load-use hazards and stalls the front end for them.
- Sequences multi-cycle MUL/DIV instructions by holding EX for a fixed latency.
- Sits between ID decode and the EX-stage operand muxes. Owns no data, only control.

Parameters:
- REG_AW, 4: register address width (16 architectural registers).
- MULDIV_LAT, 4: cycles a MUL/DIV occupies EX. Legal range 1..16; a value of 1 means no stall.
- ZERO_REG, 1: when 1, register 0 is never a forwarding match.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs1  in  REG_AW  ID source register A
- id_rs2  in  REG_AW  ID source register B
- id_rd  in  REG_AW  ID destination register
- id_wr  in  1  ID instruction writes rd
- id_load  in  1  ID instruction is a load
- id_muldiv  in  1  ID instruction is MUL/DIV
- flush  in  1  branch taken in EX; squash the younger instruction entering EX
- selA  out  2  ALUSrc for operand A
- selB  out  2  ALUSrc for operand B
- stall_if  out  1  hold PC and IF/ID register
- bubble_ex  out  1  ID/EX loads a NOP this cycle
- ex_first  out  1  first cycle of the current EX instruction; MUL/DIV unit captures operands here
- busy  out  1  state is MULDIV

Behaviour:
Reset (rst_n=0 at clk edge):
- ex/mem/wb valid bits cleared; state is RUN; counter is 0.
- selA=selB=0, stall_if=0, bubble_ex=0, ex_first=0, busy=0 for the whole reset cycle.

Tracked stage records:
- ex: {valid, rs1, rs2, rd, wr, load, muldiv, first}
- mem: {valid, rd, wr}
- wb: {valid, rd, wr}

Select codes (combinational from the registered records), evaluated per operand rsX of ex:
- 1 (EX/MEM) if mem.valid & mem.wr & mem.rd==rsX.
- Else 2 (MEM/WB) if wb.valid & wb.wr & wb.rd==rsX.
- Else 0 (register file).
- With ZERO_REG=1, rsX==0 always selects 0.
- If ex.valid=0, the select is 0.
- Code 3 is never produced.

Load-use hazard (RUN only), combinational:
- Condition: ex.valid & ex.load & ex.wr & id_valid & (ex.rd==id_rs1 | ex.rd==id_rs2), with the zero-register exclusion applied.
- Outputs: stall_if=1, bubble_ex=1.
- Next edge: ex<=bubble, mem<=ex, wb<=mem.
- The hazard clears on the following cycle, so the stall is exactly 1 cycle.

State machine, states RUN and MULDIV:
- RUN, normal advance: ex<=ID record (valid=id_valid, first=1); mem<=ex; wb<=mem.
- RUN, ex.valid & ex.muldiv & ex.first & MULDIV_LAT>1:
  - stall_if=1.
  - ex held with first<=0; mem<=bubble; wb<=mem.
  - counter<=MULDIV_LAT-2; next state MULDIV.
- MULDIV, counter!=0: stall_if=1, busy=1, ex held, mem<=bubble, counter decrements.
- MULDIV, counter==0: busy=1, stall_if=0, normal advance, next state RUN.
- Result: a MUL/DIV occupies EX for exactly MULDIV_LAT cycles.
- ex_first is the registered ex.first (ex.valid & ex.first).

Flush (highest priority after reset), any state:
- ex<=bubble; mem<=ex; wb<=mem; state<=RUN; counter<=0.
- stall_if=0 and bubble_ex=1 that cycle.

Simultaneous events:
- Load-use plus the MUL/DIV entry condition cannot occur together, because EX holds a single instruction.
- In MULDIV, load-use evaluation is suppressed; the front end is already stalled.
- Reset mid-MULDIV returns to RUN with all records invalid.

Decomposition:
- Shared package cpu_ctrl_pkg:
  - SEL_RF=2'd0, SEL_EXMEM=2'd1, SEL_MEMWB=2'd2
  - state encodings ST_RUN, ST_MULDIV
  - REG_AW default
- One sub-module, fwd_sel: purely combinational priority comparator producing one 2-bit select, instantiated twice (A and B).

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with id_valid=1 → all outputs 0; after release, first ID instruction reaches EX with ex_first=1.
- Back-to-back forwarding: ADD r3 then SUB r4,r3,r3 → SUB in EX has selA=selB=1. Then insert one NOP and issue OR r5,r3,r1 → selA=2, selB=0.
- Load-use: LW r2 followed by ADD r6,r2,r7 → stall_if=1 and bubble_ex=1 for exactly 1 cycle; next cycle ADD in EX has selA=2.
- Double match: mem.rd=wb.rd=r5, EX reads r5 → select=1 (EX/MEM priority). Reading r0 with both stages writing r0 → select=0.
- MUL/DIV with MULDIV_LAT=4: MUL stays in EX 4 cycles; stall_if=1 for cycles 1-3; busy=1 for cycles 2-4; ex_first=1 only on cycle 1; 3 bubbles enter MEM. Repeat with MULDIV_LAT=1 → no stall.
- Flush in MULDIV (counter=1) and reset mid-MULDIV → next cycle state RUN, busy=0, EX empty, selA=selB=0.
